// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
//
// Sequential read-port client for the 32x32 CPU register file. A Start pulse
// in IDLE walks register indices FIRST_REG..LAST_REG through one read port
// (drives RA, captures BusA READ_LAT cycles later) and streams each value
// with its index over a valid/ready output.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   defined   : one extra word follows register LAST_REG, carrying the XOR of
//               all dumped register values with DumpIdx=0 and DumpLast=1.
//   undefined : no checksum state/register; the LAST_REG word has DumpLast=1.
//
// Parameters:
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG <= LAST_REG <= 31)
//   READ_LAT   cycles from an RA change to BusA valid at a rising edge (>= 1)
//
// Ports:
//   Clk        clock, all state updates on the rising edge
//   Rst        synchronous active-high reset; aborts a dump without Done
//   Start      begin a dump; sampled only in IDLE
//   RA         read address to the register file
//   BusA       read data from the register file
//   DumpData   current stream word
//   DumpIdx    register index of DumpData (0 for the checksum word)
//   DumpValid  DumpData/DumpIdx/DumpLast valid
//   DumpReady  consumer accepts the word
//   DumpLast   marks the final word of the dump
//   Busy       dump in progress
//   Done       one-cycle pulse after the final transfer
//   dbg_state  current FSM state (IDLE=0, ADDR=1, SEND=2, CSUM=3, DONE=4)
//
// Handshake: a word transfers on a rising edge where DumpValid && DumpReady.
// Once DumpValid is raised, DumpData/DumpIdx/DumpLast hold stable and
// DumpValid stays high until that transfer happens. All outputs are
// registered; nothing combinational runs from DumpReady or BusA to an output.
// -----------------------------------------------------------------------------
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int READ_LAT  = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    output logic [4:0]  RA,
    input  logic [31:0] BusA,
    output logic [31:0] DumpData,
    output logic [4:0]  DumpIdx,
    output logic        DumpValid,
    input  logic        DumpReady,
    output logic        DumpLast,
    output logic        Busy,
    output logic        Done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_SEND = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Wait counter just wide enough to hold READ_LAT.
    localparam int CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    localparam logic [4:0]    FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0]    LAST_IDX  = 5'(LAST_REG);
    localparam logic [CW-1:0] LAT_INIT  = CW'(READ_LAT);
    localparam logic [CW-1:0] LAT_ONE   = CW'(1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    assign dbg_state = state;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            RA        <= '0;
            DumpData  <= '0;
            DumpIdx   <= '0;
            DumpValid <= 1'b0;
            DumpLast  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state    <= S_ADDR;
                        RA       <= FIRST_IDX;
                        wait_cnt <= LAT_INIT;
                        Busy     <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end

                S_ADDR: begin
                    wait_cnt <= wait_cnt - LAT_ONE;
                    // Counter at 1 means BusA reflects RA at this edge.
                    if (wait_cnt == LAT_ONE) begin
                        DumpData  <= BusA;
                        DumpIdx   <= RA;
`ifdef REGDUMP_CHECKSUM_EN
                        // The checksum word closes the stream instead.
                        DumpLast  <= 1'b0;
`else
                        DumpLast  <= (RA == LAST_IDX);
`endif
                        DumpValid <= 1'b1;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    // DumpValid is always high in SEND, so DumpReady alone
                    // marks the transfer edge.
                    if (DumpReady) begin
`ifdef REGDUMP_CHECKSUM_EN
                        checksum <= checksum ^ DumpData;
`endif
                        if (DumpLast) begin
                            DumpValid <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                            state     <= S_DONE;
`ifdef REGDUMP_CHECKSUM_EN
                        end else if (DumpIdx == LAST_IDX) begin
                            // Drop valid for the CSUM cycle so the consumer
                            // cannot take the last register word twice.
                            DumpValid <= 1'b0;
                            state     <= S_CSUM;
`endif
                        end else begin
                            RA        <= RA + 5'd1;
                            wait_cnt  <= LAT_INIT;
                            DumpValid <= 1'b0;
                            state     <= S_ADDR;
                        end
                    end
                end

`ifdef REGDUMP_CHECKSUM_EN
                S_CSUM: begin
                    DumpData  <= checksum;
                    DumpIdx   <= 5'd0;
                    DumpLast  <= 1'b1;
                    DumpValid <= 1'b1;
                    state     <= S_SEND;
                end
`endif

                S_DONE: begin
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
//
// Bench for regfile_dump. A behavioural register file answers RA on the
// falling edge. The expected stream is built from the register array (index
// order, XOR checksum when REGDUMP_CHECKSUM_EN is defined) and compared word
// by word against what the monitor captures on each valid&&ready edge.
// A second instance (FIRST_REG=5, LAST_REG=5, READ_LAT=3) covers the
// single-register, long-latency corner.
// -----------------------------------------------------------------------------
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    // ---------------- DUT signals ----------------
    logic        Start = 1'b0;
    logic [4:0]  RA;
    logic [31:0] BusA = '0;
    logic [31:0] DumpData;
    logic [4:0]  DumpIdx;
    logic        DumpValid;
    logic        DumpReady = 1'b1;
    logic        DumpLast;
    logic        Busy;
    logic        Done;
    logic [2:0]  dbg_state;

    logic        start2 = 1'b0;
    logic [4:0]  ra2;
    logic [31:0] bus_a2 = '0;
    logic [31:0] data2;
    logic [4:0]  idx2;
    logic        valid2;
    logic        ready2 = 1'b1;
    logic        last2;
    logic        busy2;
    logic        done2;
    logic [2:0]  dbg_state2;

    regfile_dump u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .RA(RA), .BusA(BusA),
        .DumpData(DumpData), .DumpIdx(DumpIdx), .DumpValid(DumpValid),
        .DumpReady(DumpReady), .DumpLast(DumpLast), .Busy(Busy), .Done(Done),
        .dbg_state(dbg_state)
    );

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5), .READ_LAT(3)) u_one (
        .Clk(Clk), .Rst(Rst), .Start(start2), .RA(ra2), .BusA(bus_a2),
        .DumpData(data2), .DumpIdx(idx2), .DumpValid(valid2),
        .DumpReady(ready2), .DumpLast(last2), .Busy(busy2), .Done(done2),
        .dbg_state(dbg_state2)
    );

    // ---------------- register file model ----------------
    logic [31:0] rf [32];
    always @(negedge Clk) begin
        BusA   <= rf[RA];
        bus_a2 <= rf[ra2];
    end

    // ---------------- ready driver ----------------
    bit ready_rand = 1'b0;
    always @(posedge Clk) begin
        #1;
        if (ready_rand) DumpReady = 1'($urandom_range(0, 1));
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q[$];   // {last, idx, data}
    logic [37:0] got_q[$];

    function automatic void build_expected();
        logic [31:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            x ^= rf[i];
            exp_q.push_back({(CS == 0 && i == 31), 5'(i), rf[i]});
        end
        if (CS != 0) exp_q.push_back({1'b1, 5'd0, x});
    endfunction

    // ---------------- monitor ----------------
    bit          mon_en      = 1'b0;
    int          first_valid = -1;
    int          done_cyc    = -1;
    int          done_cnt    = 0;
    bit          hold_pend   = 1'b0;
    logic [37:0] hold_word;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (hold_pend)
                check("hold_stable", {DumpValid, DumpLast, DumpIdx, DumpData}, {1'b1, hold_word});
            hold_pend = DumpValid && !DumpReady;
            hold_word = {DumpLast, DumpIdx, DumpData};
            if (DumpValid && first_valid < 0) first_valid = cyc;
            if (DumpValid && DumpReady) got_q.push_back({DumpLast, DumpIdx, DumpData});
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_dump(input bit timed, input bit mid_start, input string tag);
        int k;
        logic [37:0] w;
        build_expected();
        got_q.delete();
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        hold_pend   = 1'b0;
        mon_en      = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        k = cyc;
        Start = 1'b0;
        check({tag, "_busy"}, Busy, 1'b1);
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            @(posedge Clk); #1;
            Start = mid_start && (i >= 20 && i < 22);
        end
        Start = 1'b0;
        check({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
        @(negedge Clk);
        mon_en = 1'b0;
        check({tag, "_idle_busy"}, Busy, 1'b0);
        check({tag, "_idle_done"}, Done, 1'b0);
        check({tag, "_idle_valid"}, DumpValid, 1'b0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            w = (i < got_q.size()) ? got_q[i] : 'x;
            check($sformatf("%s_word%0d", tag, i), w, exp_q[i]);
        end
        if (timed) begin
            check({tag, "_first_valid_cyc"}, first_valid, k + 1);
            check({tag, "_done_cyc"}, done_cyc, k + 64 + 2 * CS);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_main"}, {RA, DumpData, DumpIdx, DumpValid, DumpLast, Busy, Done, dbg_state}, '0);
        check({tag, "_one"}, {ra2, data2, idx2, valid2, last2, busy2, done2, dbg_state2}, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bit found;
        bit done_any;

        for (int i = 0; i < 32; i++) rf[i] = '0;
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Rst = 1'b0;

        // Preloaded pattern, ready held high, full timing.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        run_dump(1'b1, 1'b0, "t1");

        // Random data with random backpressure.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        ready_rand = 1'b1;
        run_dump(1'b0, 1'b0, "t2");
        ready_rand = 1'b0;
        @(posedge Clk); #2;
        DumpReady = 1'b1;

        // Single register, READ_LAT=3 instance.
        rf[5] = $urandom;
        @(posedge Clk); #1;
        start2 = 1'b1;
        @(posedge Clk); #1;
        start2 = 1'b0;
        @(negedge Clk); check("one_novalid_0", valid2, 1'b0);
        @(negedge Clk); check("one_novalid_1", valid2, 1'b0);
        @(negedge Clk); check("one_novalid_2", valid2, 1'b0);
        @(negedge Clk);
        check("one_word", {valid2, last2, idx2, data2}, {1'b1, (CS == 0), 5'd5, rf[5]});
        @(negedge Clk);
        check("one_done_a", done2, (CS == 0));
        if (CS != 0) begin
            @(negedge Clk);
            check("one_csum_word", {valid2, last2, idx2, data2}, {1'b1, 1'b1, 5'd0, rf[5]});
            @(negedge Clk);
            check("one_done_b", done2, 1'b1);
        end
        @(negedge Clk);
        check("one_idle", {done2, busy2, valid2}, 3'b000);

        // Reset while sending register 12.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge Clk);
            if (DumpValid && DumpIdx == 5'd12) found = 1'b1;
        end
        check("rst_mid_found_idx12", found, 1'b1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        check_reset_outputs("rst_mid");
        Rst = 1'b0;
        done_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Done || DumpValid || Busy) done_any = 1'b1;
        end
        check("rst_mid_quiet", done_any, 1'b0);
        run_dump(1'b1, 1'b0, "t4");

        // Start pulsed mid-dump is ignored.
        run_dump(1'b1, 1'b1, "t5");

        // Checksum pattern.
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'hA5A5_A5A5;
        rf[2] = 32'h0F0F_0F0F;
        run_dump(1'b1, 1'b0, "t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-port client for the 32×32 CPU register file. On a start pulse it walks a configured register range through one register-file read port (drives RA, captures BusA) and streams each register value with its index over a valid/ready output. It sits beside the pipeline as a debug/trace path: the bench, or a future debug UART, consumes the stream, so the register file needs no 32-wide observation bus.

## Interface
- FIRST_REG, 0, first register index dumped (0–31).
- LAST_REG, 31, last register index dumped; FIRST_REG ≤ LAST_REG.
- READ_LAT, 1, clock cycles from RA change to BusA valid at a rising edge; ≥ 1. The register file updates BusA on the falling edge, so 1 is correct for it.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Start  in  1  begin dump; sampled only in IDLE.
- RA  out  5  read address to register file.
- BusA  in  32  read data from register file.
- DumpData  out  32  current stream word.
- DumpIdx  out  5  register index of DumpData.
- DumpValid  out  1  DumpData/DumpIdx/DumpLast valid.
- DumpReady  in  1  consumer accepts word.
- DumpLast  out  1  marks final word of the dump.
- Busy  out  1  dump in progress.
- Done  out  1  one-cycle pulse after the final transfer.

## Operation
- States: IDLE, ADDR, SEND, CSUM, DONE.
- IDLE: Busy=0. On an edge with Start=1, go to ADDR, RA←FIRST_REG, wait counter←READ_LAT, checksum←0.
- ADDR: Busy=1. Each edge decrements the counter. On the edge where the counter equals 1:
  - DumpData←BusA, DumpIdx←RA.
  - DumpLast←(RA==LAST_REG) and checksum disabled.
  - DumpValid←1, go to SEND.
- SEND: Busy=1. A transfer happens on an edge where DumpValid&&DumpReady. On that edge, checksum ^= DumpData, then:
  - If this was the checksum word or DumpLast: go to DONE, DumpValid←0.
  - Else if DumpIdx==LAST_REG: go to CSUM.
  - Else RA←RA+1, counter←READ_LAT, DumpValid←0, go to ADDR.
- SEND with no transfer: DumpData, DumpIdx and DumpLast hold stable. DumpValid never drops without a transfer.
- CSUM (only with the checksum macro): load DumpData←checksum, DumpIdx←0, DumpLast←1, DumpValid←1, go to SEND.
- DONE: Done=1, Busy=0, DumpValid=0; go to IDLE on the next edge.
- Start is ignored outside IDLE. Start held high in IDLE after DONE begins a new dump.
- RA holds its last value in IDLE/DONE. The 5-bit index never wraps because LAST_REG ≤ 31.
- Reset values (at any edge with Rst=1, including mid-dump): state IDLE, RA=0, DumpData=0, DumpIdx=0, DumpValid=0, DumpLast=0, Busy=0, Done=0, checksum=0. Reset aborts the dump; no partial completion and no Done pulse.

## Timing
- Start sampled at edge k: RA=FIRST_REG after k; first DumpValid after edge k+READ_LAT.
- With DumpReady held high, each register takes READ_LAT+1 cycles.
- Defaults without checksum: 32 words in 64 cycles; Done is high for the cycle following edge k+64.
- Checksum beat adds 2 cycles (CSUM, SEND) with DumpReady high.
- Backpressure extends SEND indefinitely; read timing of the next register restarts after the transfer.
- All outputs are registered; there is no combinational path from DumpReady or BusA to any output.

## Configuration
- REGDUMP_CHECKSUM_EN defined: after register LAST_REG, one extra word is sent. It carries the XOR of all dumped register values, DumpIdx=0 and DumpLast=1; the LAST_REG word has DumpLast=0.
- REGDUMP_CHECKSUM_EN undefined: no CSUM state or checksum register; the LAST_REG word carries DumpLast=1.

## Test plan
- Reset, then registers preloaded rN=N×0x11111111 mod 2³², DumpReady=1, Start pulse -> 32 words with idx 0..31 and matching data; DumpLast only on idx 31; Done 1 cycle after edge k+64; Busy low afterwards.
- DumpReady toggled pseudo-randomly -> the same 32 words in order; data and idx stable while DumpValid=1 and DumpReady=0; no word duplicated or dropped.
- FIRST_REG=5, LAST_REG=5, READ_LAT=3 -> single word idx 5, first DumpValid 3 cycles after Start, DumpLast=1, then Done.
- Rst asserted while in SEND at idx 12 -> next edge all outputs at reset values, no Done; a new Start dumps again from FIRST_REG.
- Start pulsed again mid-dump -> ignored; stream continues unchanged.
- REGDUMP_CHECKSUM_EN, r1=0xA5A5A5A5, r2=0x0F0F0F0F, others 0 -> 33rd word 0xAAAAAAAA with idx 0 and DumpLast=1; idx-31 word has DumpLast=0.
